// File: rtl/mem_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_loop_ctrl
// Description : Strided-read loop sequencer. Steps an induction variable,
//               issues one memory read per iteration, and buffers the returned
//               words with their index in a credit-protected FWFT FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_loop_ctrl #(
   parameter int ADDR_W    = 6,
   parameter int IDX_W     = 4,
   parameter int DATA_W    = 4,
   parameter int STRIDE_SH = 2,
   parameter int MEM_LAT   = 1,
   parameter int DEPTH     = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base,
   input  logic [IDX_W:0]    trip_count,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [DATA_W-1:0] mem_data,
   output logic [DATA_W-1:0] out_data,
   output logic [IDX_W-1:0]  out_idx,
   output logic              out_valid,
   input  logic              out_ready
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [ADDR_W-1:0]   base_q, base_d;
   logic [IDX_W:0]      trip_q, trip_d;
   logic [IDX_W:0]      issued_q, issued_d;
   logic                done_q, done_d;

   // In-flight read tracking: stage k holds a read issued k+1 cycles ago.
   logic [MEM_LAT-1:0]  pv_q;
   logic [IDX_W-1:0]    pidx_q [MEM_LAT];
   logic [CNT_W-1:0]    inflight_q;

   // Result FIFO.
   logic [DATA_W-1:0]   fdata_q [DEPTH];
   logic [IDX_W-1:0]    fidx_q  [DEPTH];
   logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]    cnt_q, cnt_d;

   logic                w_issue;
   logic                w_push;
   logic                w_pop;
   logic                w_credit_ok;
   logic [IDX_W-1:0]    w_ip1;
   logic [ADDR_W-1:0]   w_off;

   // Credit uses registered counts only, so a pop frees space one cycle later.
   assign w_credit_ok = ({1'b0, inflight_q} + {1'b0, cnt_q}) < (CNT_W+1)'(DEPTH);
   assign w_push      = pv_q[MEM_LAT-1];
   assign out_valid   = (cnt_q != '0);
   assign w_pop       = out_valid && out_ready;
   assign cnt_d       = cnt_q + CNT_W'(w_push) - CNT_W'(w_pop);

   // (i+1) wraps in IDX_W bits before being widened and shifted.
   assign w_ip1     = issued_q[IDX_W-1:0] + IDX_W'(1);
   assign w_off     = ADDR_W'(w_ip1) << STRIDE_SH;
   assign mem_rd_en = w_issue;
   assign mem_addr  = w_issue ? (base_q + w_off) : '0;

   assign busy     = (state_q != S_IDLE);
   assign done     = done_q;
   assign out_data = out_valid ? fdata_q[rd_ptr_q] : '0;
   assign out_idx  = out_valid ? fidx_q[rd_ptr_q]  : '0;

   // Loop FSM next-state, issue decision and completion pulse.
   always_comb begin
      state_d  = state_q;
      base_d   = base_q;
      trip_d   = trip_q;
      issued_d = issued_q;
      done_d   = 1'b0;
      w_issue  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (start) begin
               if (trip_count == '0) begin
                  done_d = 1'b1;
               end else begin
                  state_d  = S_RUN;
                  base_d   = base;
                  trip_d   = trip_count;
                  issued_d = '0;
               end
            end
         end
         S_RUN: begin
            if (w_credit_ok) begin
               w_issue  = 1'b1;
               issued_d = issued_q + (IDX_W+1)'(1);
               if (issued_d == trip_q) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: begin
            // Leave as soon as the last word is being popped this cycle.
            if ((pv_q == '0) && (cnt_d == '0)) begin
               state_d = S_IDLE;
               done_d  = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Control state registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         base_q   <= '0;
         trip_q   <= '0;
         issued_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         base_q   <= base_d;
         trip_q   <= trip_d;
         issued_q <= issued_d;
         done_q   <= done_d;
      end
   end

   // Read-latency shift register carrying valid and index of each read.
   always_ff @(posedge clk) begin
      if (rst) begin
         pv_q       <= '0;
         inflight_q <= '0;
         for (int k = 0; k < MEM_LAT; k++) pidx_q[k] <= '0;
      end else begin
         for (int k = MEM_LAT-1; k > 0; k--) begin
            pv_q[k]   <= pv_q[k-1];
            pidx_q[k] <= pidx_q[k-1];
         end
         pv_q[0]    <= w_issue;
         pidx_q[0]  <= issued_q[IDX_W-1:0];
         inflight_q <= inflight_q + CNT_W'(w_issue) - CNT_W'(w_push);
      end
   end

   // FIFO pointers and occupancy.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
         if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         cnt_q <= cnt_d;
      end
   end

   // FIFO storage; contents are only visible through the occupancy count.
   always_ff @(posedge clk) begin
      if (w_push) begin
         fdata_q[wr_ptr_q] <= mem_data;
         fidx_q[wr_ptr_q]  <= pidx_q[MEM_LAT-1];
      end
   end

   // The credit check must make a push into a full FIFO impossible.
   a_no_overflow : assert property (@(posedge clk) disable iff (rst)
                                    !(w_push && (cnt_q == CNT_W'(DEPTH))));

endmodule
`default_nettype wire

// File: tb/tb_mem_loop_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_loop_ctrl
// Description : Scoreboard bench for mem_loop_ctrl (MEM_LAT=1 and MEM_LAT=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_loop_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- MEM_LAT = 1 instance ----------------
   logic       rst = 1'b1, start = 1'b0, out_ready = 1'b1;
   logic [5:0] base = '0;
   logic [4:0] trip = '0;
   logic       busy, done, mem_rd_en, out_valid;
   logic [5:0] mem_addr;
   logic [3:0] mem_data = '0, out_data, out_idx;

   mem_loop_ctrl #(.MEM_LAT(1), .DEPTH(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .base(base), .trip_count(trip),
      .busy(busy), .done(done), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
      .mem_data(mem_data), .out_data(out_data), .out_idx(out_idx),
      .out_valid(out_valid), .out_ready(out_ready));

   // Memory returns addr[3:0] one cycle after the request.
   always @(posedge clk) mem_data <= mem_addr[3:0];

   // ---------------- MEM_LAT = 3 instance ----------------
   logic       start3 = 1'b0, ready3 = 1'b1, rnd3_en = 1'b0;
   logic [5:0] base3 = '0;
   logic [4:0] trip3 = '0;
   logic       busy3, done3, rd3_en, valid3;
   logic [5:0] addr3;
   logic [3:0] mdata3, data3, idx3;
   logic [3:0] m3 [3];

   mem_loop_ctrl #(.MEM_LAT(3), .DEPTH(4)) u_dut3 (
      .clk(clk), .rst(rst), .start(start3), .base(base3), .trip_count(trip3),
      .busy(busy3), .done(done3), .mem_addr(addr3), .mem_rd_en(rd3_en),
      .mem_data(mdata3), .out_data(data3), .out_idx(idx3),
      .out_valid(valid3), .out_ready(ready3));

   always @(posedge clk) begin
      m3[0] <= addr3[3:0];
      m3[1] <= m3[0];
      m3[2] <= m3[1];
   end
   assign mdata3 = m3[2];

   initial begin
      forever begin
         @(posedge clk);
         #1;
         ready3 = rnd3_en ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // ---------------- scoreboard state ----------------
   logic [5:0] exp_addr_q [$];
   logic [7:0] exp_out_q  [$];
   logic [7:0] exp3_q     [$];
   int rd_cnt, out_cnt, done_cnt, first_rd_cyc, first_out_cyc, t0;
   int first_rd_addr, last_rd_addr;
   int rd3 = 0, out3 = 0, done3_cnt = 0;
   logic       stall_prev = 1'b0;
   logic [7:0] held = '0;

   task automatic chk(input string name, input int act, input int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic extra(input string name, input int act);
      tests++;
      fails++;
      $display("FAIL %s: got %0d expected no transfer", name, act);
   endtask

   function automatic logic [5:0] model_addr(input logic [5:0] b, input int i);
      logic [3:0] ip1;
      logic [5:0] off;
      ip1 = 4'(i + 1);
      off = {2'b00, ip1};
      off = off << 2;
      return b + off;
   endfunction

   // Monitor for the MEM_LAT=1 instance: reads, outputs, hold, done.
   always @(negedge clk) begin
      if (!rst) begin
         if (mem_rd_en) begin
            if (rd_cnt == 0) begin
               first_rd_cyc  = cyc;
               first_rd_addr = mem_addr;
            end
            last_rd_addr = mem_addr;
            rd_cnt++;
            if (exp_addr_q.size() == 0) extra("read_extra", mem_addr);
            else chk("mem_addr", mem_addr, exp_addr_q.pop_front());
         end
         if (stall_prev && out_valid) chk("hold_idx_data", {out_idx, out_data}, held);
         stall_prev = out_valid && !out_ready;
         held       = {out_idx, out_data};
         if (out_valid && out_ready) begin
            if (out_cnt == 0) first_out_cyc = cyc;
            out_cnt++;
            if (exp_out_q.size() == 0) extra("out_extra", {out_idx, out_data});
            else chk("out_idx_data", {out_idx, out_data}, exp_out_q.pop_front());
         end
         if (done) done_cnt++;
      end
   end

   // Monitor for the MEM_LAT=3 instance: push on issue, pop on output.
   always @(negedge clk) begin
      if (!rst) begin
         if (rd3_en) begin
            chk("lat3_addr", addr3, model_addr(base3, rd3));
            exp3_q.push_back({4'(rd3), addr3[3:0]});
            rd3++;
         end
         if (valid3 && ready3) begin
            out3++;
            if (exp3_q.size() == 0) extra("lat3_out_extra", {idx3, data3});
            else chk("lat3_out", {idx3, data3}, exp3_q.pop_front());
         end
         if (done3) done3_cnt++;
      end
   end

   task automatic step(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic launch(input logic [5:0] b, input logic [4:0] t);
      rd_cnt = 0; out_cnt = 0; done_cnt = 0;
      first_rd_cyc = -1; first_out_cyc = -1;
      start = 1'b1; base = b; trip = t; t0 = cyc;
      step();
      start = 1'b0;
   endtask

   task automatic push_model(input logic [5:0] b, input int t);
      logic [5:0] a;
      for (int i = 0; i < t; i++) begin
         a = model_addr(b, i);
         exp_addr_q.push_back(a);
         exp_out_q.push_back({4'(i), a[3:0]});
      end
   endtask

   task automatic wait_done(input string name, input int limit, output int dc);
      int k;
      dc = -1;
      for (k = 0; k < limit; k++) begin
         @(negedge clk);
         if (done) break;
      end
      if (k == limit) extra({name, "_done_timeout"}, limit);
      else dc = cyc;
      step();
   endtask

   task automatic check_idle_outputs(input string name);
      chk({name, "_busy"}, busy, 0);
      chk({name, "_rd_en"}, mem_rd_en, 0);
      chk({name, "_addr"}, mem_addr, 0);
      chk({name, "_valid"}, out_valid, 0);
      chk({name, "_data_idx"}, {out_idx, out_data}, 0);
   endtask

   int dc;

   initial begin
      // Reset state.
      step(3);
      rst = 1'b0;
      @(negedge clk);
      check_idle_outputs("reset");
      chk("reset_done", done, 0);
      chk("reset_lat3_busy", busy3, 0);
      step();

      // Basic: hand-computed addresses and outputs, minimum latency.
      out_ready = 1'b1;
      exp_addr_q = '{6'd4, 6'd8, 6'd12, 6'd16};
      exp_out_q  = '{8'h04, 8'h18, 8'h2C, 8'h30};
      launch(6'd0, 5'd4);
      wait_done("basic", 40, dc);
      chk("basic_first_read_cycle", first_rd_cyc - t0, 1);
      chk("basic_first_out_cycle", first_out_cyc - t0, 3);
      chk("basic_done_cycle", dc - t0, 7);
      step(3);
      chk("basic_reads", rd_cnt, 4);
      chk("basic_outs", out_cnt, 4);
      chk("basic_done_count", done_cnt, 1);
      chk("basic_busy_after", busy, 0);

      // Wrap: base 60, 16 iterations.
      push_model(6'd60, 16);
      launch(6'd60, 5'd16);
      wait_done("wrap", 100, dc);
      step(2);
      chk("wrap_first_addr", first_rd_addr, 0);
      chk("wrap_last_addr", last_rd_addr, 60);
      chk("wrap_reads", rd_cnt, 16);
      chk("wrap_outs", out_cnt, 16);
      chk("wrap_done_count", done_cnt, 1);

      // Backpressure: issue must stop after DEPTH reads.
      out_ready = 1'b0;
      push_model(6'd0, 8);
      launch(6'd0, 5'd8);
      step(20);
      chk("bp_reads_stalled", rd_cnt, 4);
      chk("bp_head_valid", out_valid, 1);
      chk("bp_head_idx", out_idx, 0);
      chk("bp_busy", busy, 1);
      out_ready = 1'b1;
      wait_done("bp", 100, dc);
      step(2);
      chk("bp_reads", rd_cnt, 8);
      chk("bp_outs", out_cnt, 8);
      chk("bp_done_count", done_cnt, 1);

      // Zero trip count: done next cycle, no reads.
      launch(6'd5, 5'd0);
      @(negedge clk);
      chk("zero_done_pulse", done, 1);
      chk("zero_busy", busy, 0);
      @(negedge clk);
      chk("zero_done_one_cycle", done, 0);
      chk("zero_reads", rd_cnt, 0);
      step();

      // Start while busy is ignored.
      push_model(6'd16, 6);
      launch(6'd16, 5'd6);
      step(2);
      start = 1'b1; base = 6'd40; trip = 5'd3;
      step();
      start = 1'b0;
      wait_done("busy_start", 60, dc);
      step(3);
      chk("busy_start_reads", rd_cnt, 6);
      chk("busy_start_outs", out_cnt, 6);
      chk("busy_start_done_count", done_cnt, 1);

      // Reset mid-run after three reads.
      push_model(6'd0, 8);
      launch(6'd0, 5'd8);
      begin
         int k;
         for (k = 0; k < 20; k++) begin
            @(negedge clk);
            if (rd_cnt == 3) break;
         end
         if (k == 20) extra("rst_wait_timeout", rd_cnt);
      end
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      exp_addr_q.delete();
      exp_out_q.delete();
      stall_prev = 1'b0;
      @(negedge clk);
      check_idle_outputs("midrst");
      chk("midrst_done", done, 0);
      step();
      exp_addr_q = '{6'd12, 6'd16};
      exp_out_q  = '{8'h0C, 8'h10};
      launch(6'd8, 5'd2);
      wait_done("midrst_fresh", 40, dc);
      step(3);
      chk("midrst_fresh_reads", rd_cnt, 2);
      chk("midrst_fresh_outs", out_cnt, 2);
      chk("midrst_fresh_done_count", done_cnt, 1);

      chk("sb_addr_queue_empty", exp_addr_q.size(), 0);
      chk("sb_out_queue_empty", exp_out_q.size(), 0);

      // Latency sweep on the MEM_LAT=3 instance with random backpressure.
      rnd3_en = 1'b1;
      rd3 = 0; out3 = 0; done3_cnt = 0;
      start3 = 1'b1; base3 = 6'd20; trip3 = 5'd16;
      step();
      start3 = 1'b0;
      begin
         int k;
         for (k = 0; k < 400; k++) begin
            @(negedge clk);
            if (done3) break;
         end
         if (k == 400) extra("lat3_done_timeout", out3);
      end
      step(4);
      rnd3_en = 1'b0;
      chk("lat3_reads", rd3, 16);
      chk("lat3_outs", out3, 16);
      chk("lat3_done_count", done3_cnt, 1);
      chk("lat3_queue_empty", exp3_q.size(), 0);
      chk("lat3_busy_after", busy3, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish, %0d tests %0d failed", tests, fails);
      $fatal(1);
   end

endmodule
`default_nettype wire
